lamp_scan_decoder: RTL and testbench

- Parametrised, registered successor to the team's 3-to-8 lamp decoder: SEL_W-bit select driving 2^SEL_W active-low one-hot lamp outputs, with the same G / G2A / G2B enable gating.
- Adds an auto-scan mode: an internal prescaler and index counter step the active output up or down at a programmable rate, with a wrap pulse.
- Sits between the lamp-control logic and the lamp/LED pins.

---
 rtl/lamp_scan_decoder_if.sv | 31 +++
 rtl/lamp_scan_decoder.sv | 94 +++++++++
 tb/tb_lamp_scan_decoder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/lamp_scan_decoder_if.sv
// Lamp decoder bus: the select/enable/scan controls toward the decoder and
// the registered lamp, index and wrap outputs back from it.
interface lamp_scan_decoder_if #(
  parameter int SEL_W = 3,
  parameter int DIV_W = 16
);
  localparam int OUTS = 1 << SEL_W;

  logic [SEL_W-1:0] sel;
  logic             G;
  logic             G2A;
  logic             G2B;
  logic             mode;
  logic             dir;
  logic [DIV_W-1:0] period;
  logic [OUTS-1:0]  Y;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  // Lamp-control side: drives select, enables and scan controls.
  modport master (
    output sel, G, G2A, G2B, mode, dir, period,
    input  Y, idx, wrap
  );

  // Decoder side: consumes controls, drives the lamp pins.
  modport slave (
    input  sel, G, G2A, G2B, mode, dir, period,
    output Y, idx, wrap
  );
endinterface

// File: rtl/lamp_scan_decoder.sv
// Registered SEL_W-to-2^SEL_W active-low lamp decoder with G/G2A/G2B
// enable gating and an auto-scan mode that steps the lit output up or down
// every period+1 enabled cycles, pulsing wrap when the index rolls over.
module lamp_scan_decoder #(
  parameter int SEL_W   = 3,
  parameter int DIV_W   = 16,
  parameter int RST_IDX = 0
) (
  input  logic                clk,
  input  logic                rst,
  lamp_scan_decoder_if.slave  bus
);

  localparam int OUTS = 1 << SEL_W;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  mode_e            mode_s;
  logic             en;
  logic [SEL_W-1:0] idx_d,   idx_q;
  logic [DIV_W-1:0] presc_d, presc_q;
  logic             wrap_d,  wrap_q;
  logic [OUTS-1:0]  y_d,     y_q;

  assign mode_s = mode_e'(bus.mode);
  assign en     = bus.G & ~bus.G2A & ~bus.G2B;

  // Next index, prescaler and wrap: manual follows sel, scan steps on tick.
  always_comb begin
    idx_d   = idx_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    case (mode_s)
      MODE_MANUAL: begin
        idx_d   = bus.sel;
        presc_d = '0;
      end
      MODE_SCAN: begin
        if (en) begin
          // ">=" rather than "==" so lowering period below the running
          // count ticks on the next edge instead of waiting for rollover.
          if (presc_q >= bus.period) begin
            presc_d = '0;
            if (bus.dir) begin
              idx_d  = idx_q - SEL_W'(1);
              wrap_d = (idx_q == '0);
            end else begin
              idx_d  = idx_q + SEL_W'(1);
              wrap_d = (idx_q == '1);
            end
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
        end
      end
      default: begin
        idx_d   = idx_q;
        presc_d = presc_q;
      end
    endcase
  end

  // Lamp pattern follows the index being loaded this edge, so Y and idx
  // always change together.
  always_comb begin
    y_d = '1;
    for (int unsigned i = 0; i < OUTS; i++) begin
      y_d[i] = !(en && (idx_d == SEL_W'(i)));
    end
  end

  // State and output registers; reset forces all lamps off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= SEL_W'(RST_IDX);
      presc_q <= '0;
      wrap_q  <= 1'b0;
      y_q     <= '1;
    end else begin
      idx_q   <= idx_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
      y_q     <= y_d;
    end
  end

  assign bus.Y    = y_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_lamp_scan_decoder.sv
// Bench for lamp_scan_decoder: an 8-lamp and a 16-lamp instance share one
// set of stimulus and are compared every cycle against an integer model.
module tb_lamp_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  sel;
  logic        G, G2A, G2B, mode, dir;
  logic [15:0] period;

  int n_tests = 0;
  int n_fail  = 0;

  lamp_scan_decoder_if #(.SEL_W(3), .DIV_W(16)) if3 ();
  lamp_scan_decoder_if #(.SEL_W(4), .DIV_W(16)) if4 ();

  assign if3.sel    = sel[2:0];
  assign if3.G      = G;
  assign if3.G2A    = G2A;
  assign if3.G2B    = G2B;
  assign if3.mode   = mode;
  assign if3.dir    = dir;
  assign if3.period = period;
  assign if4.sel    = sel;
  assign if4.G      = G;
  assign if4.G2A    = G2A;
  assign if4.G2B    = G2B;
  assign if4.mode   = mode;
  assign if4.dir    = dir;
  assign if4.period = period;

  lamp_scan_decoder #(.SEL_W(3), .DIV_W(16), .RST_IDX(0)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3.slave)
  );

  lamp_scan_decoder #(.SEL_W(4), .DIV_W(16), .RST_IDX(5)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers, index kept modulo the lamp count.
  int outs    [2] = '{8, 16};
  int rst_idx [2] = '{0, 5};
  int m_idx   [2];
  int m_presc [2];
  int m_wrap  [2];
  int m_y     [2];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idx[k]   = rst_idx[k];
      m_presc[k] = 0;
      m_wrap[k]  = 0;
      m_y[k]     = (1 << outs[k]) - 1;
    end
  endtask

  task automatic model_edge();
    bit en;
    int o;
    int prev;
    en = G && !G2A && !G2B;
    for (int k = 0; k < 2; k++) begin
      o = outs[k];
      m_wrap[k] = 0;
      if (!mode) begin
        m_idx[k]   = int'(sel) % o;
        m_presc[k] = 0;
      end else if (en) begin
        if (m_presc[k] >= int'(period)) begin
          m_presc[k] = 0;
          prev       = m_idx[k];
          m_idx[k]   = dir ? (prev + o - 1) % o : (prev + 1) % o;
          m_wrap[k]  = dir ? int'(prev == 0) : int'(prev == o - 1);
        end else begin
          m_presc[k] = m_presc[k] + 1;
        end
      end
      m_y[k] = en ? (((1 << o) - 1) & ~(1 << m_idx[k])) : ((1 << o) - 1);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_y3"},    32'(if3.Y),    32'(m_y[0]));
    check_eq({tag, "_idx3"},  32'(if3.idx),  32'(m_idx[0]));
    check_eq({tag, "_wrap3"}, 32'(if3.wrap), 32'(m_wrap[0]));
    check_eq({tag, "_y4"},    32'(if4.Y),    32'(m_y[1]));
    check_eq({tag, "_idx4"},  32'(if4.idx),  32'(m_idx[1]));
    check_eq({tag, "_wrap4"}, 32'(if4.wrap), 32'(m_wrap[1]));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  logic [7:0] man_y [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  initial begin
    int pidx;
    int waited;
    sel = '0; G = 1'b0; G2A = 1'b0; G2B = 1'b0;
    mode = 1'b0; dir = 1'b0; period = '0;

    // Reset values, held across clock edges while rst is high.
    #1 rst = 1'b1;
    model_reset();
    #2 check_all("reset");
    repeat (2) @(posedge clk);
    #1 check_all("reset_hold");
    @(negedge clk) rst = 1'b0;

    // Manual decode sweep with explicit lamp patterns.
    G = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel = 4'(s);
      cycle("man");
      check_eq("man_lit", 32'(if3.Y), 32'(man_y[s]));
    end

    // Each disable input blanks the lamps; clearing it restores sel=5.
    sel = 4'd5;
    cycle("dis_pre");
    for (int d = 0; d < 3; d++) begin
      if (d == 0) G2A = 1'b1;
      if (d == 1) G   = 1'b0;
      if (d == 2) G2B = 1'b1;
      cycle("dis");
      check_eq("dis_off", 32'(if3.Y), 32'h0FF);
      G = 1'b1; G2A = 1'b0; G2B = 1'b0;
      cycle("dis_clr");
      check_eq("dis_on", 32'(if3.Y), 32'h0DF);
    end

    // Up-scan, period 2: 8-lamp goes 6,7,0 and 16-lamp goes 14,15,0.
    sel = 4'd14;
    cycle("up_load");
    mode = 1'b1; period = 16'd2; dir = 1'b0;
    repeat (9) cycle("scan_up");

    // Down-scan every cycle from 1.
    mode = 1'b0; sel = 4'd1;
    cycle("dn_load");
    mode = 1'b1; period = 16'd0; dir = 1'b1;
    repeat (4) cycle("scan_dn");

    // Lowering period below the running count ticks on the next edge.
    mode = 1'b0; sel = 4'd2;
    cycle("lo_load");
    mode = 1'b1; period = 16'd10; dir = 1'b0;
    waited = 0;
    while (m_presc[0] != 7 && waited < 20) begin
      cycle("lo_wait");
      waited++;
    end
    check_eq("lo_reach7", 32'(m_presc[0]), 32'd7);
    period = 16'd3;
    pidx = int'(if3.idx);
    cycle("lo_tick");
    check_eq("lo_tick_idx", 32'(if3.idx), 32'((pidx + 1) % 8));
    repeat (2) cycle("lo_dwell");
    G = 1'b0;
    repeat (5) cycle("lo_frozen");
    G = 1'b1;
    repeat (6) cycle("lo_resume");

    // Asynchronous reset mid-scan, between clock edges.
    period = 16'd1;
    repeat (3) cycle("ar_pre");
    @(posedge clk);
    model_edge();
    #3 rst = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk) rst = 1'b0;
    cycle("ar_post");

    // Randomized stimulus with sticky mode and mostly-enabled gating.
    repeat (600) begin
      sel    = 4'($urandom_range(0, 15));
      G      = ($urandom_range(0, 9) != 0);
      G2A    = ($urandom_range(0, 11) == 0);
      G2B    = ($urandom_range(0, 11) == 0);
      dir    = ($urandom_range(0, 7) == 0) ? ~dir : dir;
      if ($urandom_range(0, 11) == 0) mode = ~mode;
      if ($urandom_range(0, 5) == 0) period = 16'($urandom_range(0, 5));
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
